// File: rtl/uart_tx_port_if.sv
// Processor data-memory bus as seen by the UART transmit port.
// The processor drives address/data/strobe; the port returns the status read value.
interface uart_tx_port_if;
    logic [15:0] mem_addr;
    logic [15:0] mem_write_value;
    logic        mem_write_enable;
    logic [15:0] read_value;

    modport master (
        output mem_addr,
        output mem_write_value,
        output mem_write_enable,
        input  read_value
    );

    modport slave (
        input  mem_addr,
        input  mem_write_value,
        input  mem_write_enable,
        output read_value
    );
endinterface

// File: rtl/uart_tx_port.sv
// Memory-mapped UART transmitter: 4-entry byte FIFO feeding an 8N1 serializer.
// Data register at BASE_ADDR, status register (read; write clears overflow) at BASE_ADDR+1.
module uart_tx_port #(
    parameter int          CLOCKS_PER_BIT = 16,
    parameter logic [15:0] BASE_ADDR      = 16'hFFF0
) (
    input  logic           clk,
    input  logic           reset,
    uart_tx_port_if.slave  bus,
    output logic           uart_tx,
    output logic           tx_busy,
    output logic           fifo_full
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [15:0] STAT_ADDR = BASE_ADDR + 16'd1;
    localparam logic [15:0] BAUD_LAST = 16'(CLOCKS_PER_BIT - 1);

    state_t      state_q, state_d;
    logic [7:0]  mem_q [4];
    logic [7:0]  mem_d [4];
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  count_q, count_d;
    logic        overflow_q, overflow_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [15:0] baud_q, baud_d;
    logic        uart_tx_q, uart_tx_d;

    logic push_req, clr_req, push, pop, bit_end;
    logic unused_hi;

    assign unused_hi = ^bus.mem_write_value[15:8];
    assign push_req  = bus.mem_write_enable && (bus.mem_addr == BASE_ADDR);
    assign clr_req   = bus.mem_write_enable && (bus.mem_addr == STAT_ADDR);
    assign bit_end   = (baud_q == BAUD_LAST);

    always_comb begin
        state_d    = state_q;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        baud_d     = baud_q;
        uart_tx_d  = 1'b1;
        pop        = 1'b0;

        // uart_tx follows the current state, so the line lags the FSM by one cycle
        case (state_q)
            IDLE: begin
                uart_tx_d = 1'b1;
                if (count_q != 3'd0) begin
                    pop     = 1'b1;
                    state_d = START;
                    baud_d  = 16'd0;
                end
            end
            START: begin
                uart_tx_d = 1'b0;
                if (bit_end) begin
                    state_d   = DATA;
                    bit_idx_d = 3'd0;
                    baud_d    = 16'd0;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            DATA: begin
                uart_tx_d = shift_q[0];
                if (bit_end) begin
                    baud_d  = 16'd0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) state_d = STOP;
                    else bit_idx_d = bit_idx_q + 3'd1;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            STOP: begin
                uart_tx_d = 1'b1;
                if (bit_end) begin
                    baud_d = 16'd0;
                    if (count_q != 3'd0) begin
                        pop     = 1'b1;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (pop) begin
            shift_d  = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + 2'd1;
        end

        // a pop in the same cycle frees the slot, so a full FIFO still accepts
        push = push_req && ((count_q != 3'd4) || pop);
        if (push) begin
            mem_d[wr_ptr_q] = bus.mem_write_value[7:0];
            wr_ptr_d        = wr_ptr_q + 2'd1;
        end

        count_d = count_q + 3'(push) - 3'(pop);

        if (clr_req)              overflow_d = 1'b0;
        else if (push_req && !push) overflow_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            count_q    <= 3'd0;
            overflow_q <= 1'b0;
            shift_q    <= 8'd0;
            bit_idx_q  <= 3'd0;
            baud_q     <= 16'd0;
            uart_tx_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            baud_q     <= baud_d;
            uart_tx_q  <= uart_tx_d;
        end
    end

    assign uart_tx   = uart_tx_q;
    assign tx_busy   = (state_q != IDLE);
    assign fifo_full = (count_q == 3'd4);

    assign bus.read_value = (bus.mem_addr == STAT_ADDR)
                          ? {12'd0, (count_q == 3'd0), overflow_q, tx_busy, fifo_full}
                          : 16'd0;
endmodule

// File: doc/uart_tx_port.md
UART_TX_PORT -- requirements
Module: uart_tx_port

Interface
REQ-001 Parameter CLOCKS_PER_BIT, default 16: clk cycles per serial bit, legal range 2..65535.
REQ-002 Parameter BASE_ADDR, default 16'hFFF0: data register at BASE_ADDR; status register at BASE_ADDR+1.
REQ-003 Port clk, input, 1: single clock; all state changes on the rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port mem_addr, input, 16: processor data-memory address.
REQ-006 Port mem_write_value, input, 16: processor write data; bits [7:0] carry the byte.
REQ-007 Port mem_write_enable, input, 1: processor write strobe, one cycle per store.
REQ-008 Port read_value, output, 16: status word when mem_addr==BASE_ADDR+1, else 0; combinational.
REQ-009 Port uart_tx, output, 1: serial line, registered, idle high.
REQ-010 Port tx_busy, output, 1: high while the serializer is not in IDLE.
REQ-011 Port fifo_full, output, 1: high when the FIFO holds 4 entries.

Function
REQ-012 The block SHALL contain a 4-entry x 8-bit FIFO with 2-bit read/write pointers wrapping 3->0 and a 3-bit count 0..4.
REQ-013 A write is a cycle with mem_write_enable=1 and mem_addr==BASE_ADDR; it pushes mem_write_value[7:0] at that edge.
REQ-014 A write at count 4 with no pop at the same edge SHALL be dropped and SHALL set a sticky overflow flag.
REQ-015 A write at count 4 with a pop at the same edge SHALL be accepted; count stays 4.
REQ-016 A write at count 0 SHALL NOT bypass the FIFO; the byte is popped at the next edge at the earliest.
REQ-017 Writing any value to BASE_ADDR+1 SHALL clear the overflow flag; it never pushes data.
REQ-018 Status word: bit0 fifo_full, bit1 tx_busy, bit2 overflow, bit3 FIFO empty, bits[15:4] zero.
REQ-019 Serializer states: IDLE, START, DATA, STOP, with a 16-bit baud counter and a 3-bit bit index.
REQ-020 IDLE: uart_tx=1; if count>0, pop into an 8-bit shift register, go to START, clear the baud counter.
REQ-021 START: uart_tx=0 for CLOCKS_PER_BIT cycles, then go to DATA with bit index 0.
REQ-022 DATA: uart_tx=shift[0] for CLOCKS_PER_BIT cycles per bit, LSB first; shift right after each bit; after bit 7, go to STOP.
REQ-023 STOP: uart_tx=1 for CLOCKS_PER_BIT cycles; then pop and go to START if count>0, else go to IDLE.
REQ-024 A frame SHALL last exactly 10*CLOCKS_PER_BIT cycles, and back-to-back frames SHALL have no idle gap.
REQ-025 Latency: a write accepted at edge N SHALL drive uart_tx low from edge N+2 when IDLE and the FIFO was empty.
REQ-026 The baud counter counts 0..CLOCKS_PER_BIT-1, and a bit ends on the edge where it equals CLOCKS_PER_BIT-1.
REQ-027 Writes SHALL be accepted in every serializer state; the FIFO and serializer operate concurrently.

Reset
REQ-028 While reset=1, at each edge: state=IDLE; uart_tx=1; tx_busy=0; count, pointers, bit index and baud counter=0; overflow=0.
REQ-029 Reset mid-frame SHALL abort the frame (uart_tx high at the next edge) and discard all FIFO contents.
REQ-030 Writes presented during reset SHALL be ignored.

Verification
REQ-031 CLOCKS_PER_BIT=4; write 8'hA5 once.
  - Expected: uart_tx 1,0,1,0,1,0,0,1,0,1,1 with 4 cycles per level from edge N+2.
  - Expected: tx_busy falls after 40 cycles.
REQ-032 Write 8'h01, 8'h02, 8'h03 on consecutive cycles.
  - Expected: three frames of 40 cycles each, no gap between them.
  - Expected: status bit3=1 after the last pop.
REQ-033 Write 6 bytes on consecutive cycles starting from idle.
  - Expected: first popped, next 4 fill the FIFO, sixth dropped.
  - Expected: fifo_full=1 and status reads 16'h0007 during frame 1.
  - Expected: write to BASE_ADDR+1 reads back 16'h0003.
REQ-034 With FIFO full, write at the exact edge STOP completes (pop).
  - Expected: byte accepted, count stays 4, overflow stays 0.
REQ-035 Assert reset 1 cycle during DATA bit 3 with 2 bytes queued.
  - Expected: uart_tx=1, tx_busy=0, status 16'h0008 next cycle.
  - Expected: no further frames.
REQ-036 Write to BASE_ADDR+2 and to BASE_ADDR-1.
  - Expected: no FIFO change.
  - Expected: read_value=0 at those addresses.
